// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Double-buffered async serial transmitter (start, LSB-first data,
//            optional even parity via UART_TX_PARITY_EN, stop bits).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_pi,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic                 tx_so,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_overrun
);

    localparam int c_STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int c_BAUD_W    = $clog2(c_STOP_CLKS);
    localparam int c_BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_BAUD_W-1:0] c_BIT_LAST  = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_STOP_LAST = c_BAUD_W'(c_STOP_CLKS - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    state_t                 state_q,     state_d;
    logic [c_BAUD_W-1:0]    baud_q,      baud_d;
    logic [c_BIT_W-1:0]     bit_q,       bit_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [DATA_BITS-1:0]   hold_q,      hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   so_q,        so_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   overrun_q,   overrun_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q,    parity_d;
`endif

    logic                   w_bit_wrap;
    logic                   w_start;

    assign w_bit_wrap = (baud_q == c_BIT_LAST);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        so_d        = so_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        w_start     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        // Handshake decisions use the pre-edge buffer state, so a load coinciding
        // with a buffer-to-shift transfer is rejected as an overrun.
        if (tx_load) begin
            if (hold_full_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_d      = tx_pi;
                hold_full_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (hold_full_q) begin
                    w_start = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    so_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + c_BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_wrap) begin
                    baud_d = '0;
                    if (bit_q == c_DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        so_d    = parity_q;
                        state_d = S_PARITY;
`else
                        so_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        so_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + c_BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + c_BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_wrap) begin
                    baud_d  = '0;
                    so_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + c_BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_q == c_STOP_LAST) begin
                    baud_d = '0;
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        w_start = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + c_BAUD_W'(1);
                end
            end
            default: begin
                baud_d  = '0;
                so_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Shared by IDLE and the gapless STOP-to-START hand-over.
        if (w_start) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            so_d        = 1'b0;
            busy_d      = 1'b1;
            baud_d      = '0;
            state_d     = S_START;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            so_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            so_q        <= so_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_ready   = ~hold_full_q;
    assign tx_so      = so_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// Testbench for uart_tx: timing-level reference model feeding a frame
// scoreboard, with a line monitor that decodes tx_so independently.
module tb_uart_tx;

    localparam int C  = 8;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (1 + DB + PB + SB) * C;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] tx_pi   = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic       tx_so;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overrun;

    uart_tx #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_pi      (tx_pi),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .tx_so      (tx_so),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overrun (tx_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    frame_t exp_q[$];

    // Reference model: a frame occupies FRAME cycles starting at its transfer edge.
    int         edge_n      = 0;
    logic       m_hold_full = 1'b0;
    logic [7:0] m_hold      = 8'h00;
    logic       m_busy      = 1'b0;
    int         m_end       = 0;
    logic       m_done      = 1'b0;
    logic       m_over      = 1'b0;
    logic       mf, mx;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hold_full = 1'b0;
                m_busy      = 1'b0;
                m_done      = 1'b0;
                m_over      = 1'b0;
                exp_q.delete();
            end else begin
                edge_n++;
                mf     = m_busy && (edge_n == m_end);
                mx     = m_hold_full && (!m_busy || mf);
                m_done = mf;
                m_over = tx_load && m_hold_full;
                if (tx_load && !m_hold_full) begin
                    m_hold      = tx_pi;
                    m_hold_full = 1'b1;
                end else if (mx) begin
                    exp_q.push_back('{data: m_hold, start: edge_n});
                    m_hold_full = 1'b0;
                    m_busy      = 1'b1;
                    m_end       = edge_n + FRAME;
                end
                if (mf && !mx) m_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n)
                check("status{ready,busy,done,overrun}",
                      {tx_ready, tx_busy, tx_done, tx_overrun},
                      {~m_hold_full, m_busy, m_done, m_over});
        end
    end

    function automatic logic exp_level(input logic [7:0] d, input int j);
        int         b;
        logic [7:0] t;
        b = j / C;
        if (b == 0) return 1'b0;
        if (b <= DB) begin
            t = d >> (b - 1);
            return t[0];
        end
        if (PB == 1 && b == DB + 1) return ^d;
        return 1'b1;
    endfunction

    // Line monitor: every low level outside a frame must be an expected start bit.
    logic       in_frame = 1'b0;
    logic       shape_ok;
    logic [7:0] dec;
    int         jpos;
    frame_t     cur;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx_so === 1'b0) begin
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur      = exp_q.pop_front();
                        check("start_edge", edge_n, cur.start);
                        in_frame = 1'b1;
                        jpos     = 0;
                        shape_ok = 1'b1;
                        dec      = 8'h00;
                    end
                end
                if (in_frame) begin
                    if (tx_so !== exp_level(cur.data, jpos)) shape_ok = 1'b0;
                    if ((jpos % C) == C / 2 && jpos / C >= 1 && jpos / C <= DB)
                        dec[jpos / C - 1] = tx_so;
                    jpos++;
                    if (jpos == FRAME) begin
                        check("frame_shape", shape_ok, 1);
                        check("frame_data", dec, cur.data);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        tx_pi   = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        tx_pi   = 8'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held
        repeat (3) @(negedge clk);
        check("reset{so,ready,busy,done,overrun}",
              {tx_so, tx_ready, tx_busy, tx_done, tx_overrun}, 5'b11000);
        rst_n = 1'b1;
        tick(20);

        // Single frame, then back-to-back with second load 20 cycles in
        load(8'h55);
        tick(FRAME + 10);
        load(8'h55);
        tick(18);
        load(8'hA5);
        tick(2 * FRAME + 10);

        // Overrun on the third load while the first frame is on the line
        load(8'h11);
        tick(3);
        load(8'h22);
        tick(3);
        load(8'h33);
        tick(2 * FRAME + 20);

        // Loads on consecutive edges: the one at the transfer edge is rejected
        @(negedge clk); tx_pi = 8'hC1; tx_load = 1'b1;
        @(negedge clk); tx_pi = 8'hC2;
        @(negedge clk); tx_pi = 8'hC3;
        @(negedge clk); tx_load = 1'b0;
        tick(2 * FRAME + 20);

        // Asynchronous reset in the middle of a frame
        load(8'hF0);
        tick(29);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset{so,busy,ready}", {tx_so, tx_busy, tx_ready}, 3'b101);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        load(8'h3C);
        tick(FRAME + 10);

        // Parity patterns (odd and even popcount)
        load(8'h07);
        tick(FRAME + 5);
        load(8'h03);
        tick(FRAME + 5);

        // Randomised traffic with varied gaps and occasional double loads
        for (int i = 0; i < 40; i++) begin
            load(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(0, FRAME));
                load(8'($urandom));
            end
            tick($urandom_range(0, 2 * FRAME));
        end

        for (int k = 0; k < 5000 && (m_busy || m_hold_full || in_frame); k++)
            @(negedge clk);
        tick(2);
        check("drained{busy,ready,queue_empty,in_frame}",
              {tx_busy, tx_ready, exp_q.size() == 0, in_frame}, 4'b0110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
